// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the core port (m0), the debug/loader port (m1),
// the arbiter and the unified memory.
interface mem_arbiter_if #(
  parameter int N = 32
);
  logic         m0_req;
  logic         m0_we;
  logic [N-1:0] m0_adr;
  logic [N-1:0] m0_wd;
  logic [N-1:0] m0_rd;
  logic         m0_ready;

  logic         m1_req;
  logic         m1_we;
  logic [N-1:0] m1_adr;
  logic [N-1:0] m1_wd;
  logic [N-1:0] m1_rd;
  logic         m1_ready;

  logic [N-1:0] mem_adr;
  logic [N-1:0] mem_wd;
  logic         mem_we;
  logic [N-1:0] mem_rd;

  // Arbiter view: serves both requesters and drives the memory.
  modport slave (
    input  m0_req, m0_we, m0_adr, m0_wd,
    output m0_rd, m0_ready,
    input  m1_req, m1_we, m1_adr, m1_wd,
    output m1_rd, m1_ready,
    output mem_adr, mem_wd, mem_we,
    input  mem_rd
  );

  // Environment view: the requesters plus the memory that answers reads.
  modport master (
    output m0_req, m0_we, m0_adr, m0_wd,
    input  m0_rd, m0_ready,
    output m1_req, m1_we, m1_adr, m1_wd,
    input  m1_rd, m1_ready,
    input  mem_adr, mem_wd, mem_we,
    output mem_rd
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the MIPS core (m0) and the debug/loader port (m1)
// one-at-a-time access to the single unified instruction/data memory.
module mem_arbiter #(
  parameter int N      = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic [1:0]    grant,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } state_t;

  localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_t        cur, nxt;
  logic [CW-1:0] cnt;
  logic          owner;      // 0 = m0, 1 = m1
  logic          last;       // most recently completed owner
  logic          we_q;
  logic [N-1:0]  adr_q, wd_q;
  logic [N-1:0]  rd0_q, rd1_q;
  logic          any_req, pick;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    pick    = bus.m1_req;
    if (bus.m0_req && bus.m1_req) pick = ~last;
    nxt = cur;
    case (cur)
      IDLE:    if (any_req) nxt = ACCESS;
      ACCESS:  nxt = we_q ? RESP : WAIT;
      WAIT:    if (cnt == CW'(1)) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, exactly as the hardware does.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur   <= IDLE;
      cnt   <= '0;
      owner <= 1'b0;
      last  <= 1'b1;   // m0 wins the first tie
      we_q  <= 1'b0;
      adr_q <= '0;
      wd_q  <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      cur <= nxt;
      case (cur)
        IDLE: begin
          if (any_req) begin
            owner <= pick;
            we_q  <= pick ? bus.m1_we  : bus.m0_we;
            adr_q <= pick ? bus.m1_adr : bus.m0_adr;
            wd_q  <= pick ? bus.m1_wd  : bus.m0_wd;
          end
        end
        ACCESS: cnt <= CW'(RD_LAT);
        WAIT: begin
          cnt <= cnt - CW'(1);
          // The last WAIT cycle is exactly RD_LAT cycles after the address cycle.
          if (cnt == CW'(1)) begin
            if (owner) rd1_q <= bus.mem_rd;
            else       rd0_q <= bus.mem_rd;
          end
        end
        RESP:    last <= owner;
        default: ;
      endcase
    end
  end

  assign bus.mem_adr  = adr_q;
  assign bus.mem_wd   = wd_q;
  assign bus.mem_we   = (cur == ACCESS) & we_q;
  assign bus.m0_rd    = rd0_q;
  assign bus.m1_rd    = rd1_q;
  assign bus.m0_ready = (cur == RESP) & ~owner;
  assign bus.m1_ready = (cur == RESP) &  owner;
  assign grant        = (cur == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign state        = cur;

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives two arbiters (RD_LAT=1 and RD_LAT=3) with identical stimulus and checks
// both against a transaction-schedule model every cycle, plus pinned literals.
module tb_mem_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         m0_req, m0_we, m1_req, m1_we;
  logic [N-1:0] m0_adr, m0_wd, m1_adr, m1_wd;
  logic [1:0]   grant_a, state_a, grant_b, state_b;

  mem_arbiter_if #(.N(N)) bus_a ();
  mem_arbiter_if #(.N(N)) bus_b ();

  mem_arbiter #(.N(N), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .grant(grant_a), .state(state_a)
  );
  mem_arbiter #(.N(N), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .grant(grant_b), .state(state_b)
  );

  always #5 clk = ~clk;

  assign bus_a.m0_req = m0_req;  assign bus_b.m0_req = m0_req;
  assign bus_a.m0_we  = m0_we;   assign bus_b.m0_we  = m0_we;
  assign bus_a.m0_adr = m0_adr;  assign bus_b.m0_adr = m0_adr;
  assign bus_a.m0_wd  = m0_wd;   assign bus_b.m0_wd  = m0_wd;
  assign bus_a.m1_req = m1_req;  assign bus_b.m1_req = m1_req;
  assign bus_a.m1_we  = m1_we;   assign bus_b.m1_we  = m1_we;
  assign bus_a.m1_adr = m1_adr;  assign bus_b.m1_adr = m1_adr;
  assign bus_a.m1_wd  = m1_wd;   assign bus_b.m1_wd  = m1_wd;

  // Observed outputs, index 0 = dut_a (RD_LAT=1), 1 = dut_b (RD_LAT=3)
  logic [1:0]   o_grant[2], o_state[2];
  logic         o_we[2], o_rdy0[2], o_rdy1[2];
  logic [N-1:0] o_adr[2], o_wd[2], o_rd0[2], o_rd1[2];

  assign o_grant[0] = grant_a;        assign o_grant[1] = grant_b;
  assign o_state[0] = state_a;        assign o_state[1] = state_b;
  assign o_we[0]    = bus_a.mem_we;   assign o_we[1]    = bus_b.mem_we;
  assign o_rdy0[0]  = bus_a.m0_ready; assign o_rdy0[1]  = bus_b.m0_ready;
  assign o_rdy1[0]  = bus_a.m1_ready; assign o_rdy1[1]  = bus_b.m1_ready;
  assign o_adr[0]   = bus_a.mem_adr;  assign o_adr[1]   = bus_b.mem_adr;
  assign o_wd[0]    = bus_a.mem_wd;   assign o_wd[1]    = bus_b.mem_wd;
  assign o_rd0[0]   = bus_a.m0_rd;    assign o_rd0[1]   = bus_b.m0_rd;
  assign o_rd1[0]   = bus_a.m1_rd;    assign o_rd1[1]   = bus_b.m1_rd;

  function automatic logic [N-1:0] seed_word(input int i);
    return 32'h9E3779B9 * (i + 7);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Memories: 64 words indexed by adr[7:2]; read data is the word addressed
  // RD_LAT cycles earlier.
  logic [N-1:0] bmem_a[64], bmem_b[64];
  logic [5:0]   pipe_a, pipe_b[3];
  bit           mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) begin
        bmem_a[i] <= seed_word(i);
        bmem_b[i] <= seed_word(i);
      end
      mem_init <= 1'b1;
    end else begin
      if (bus_a.mem_we === 1'b1) bmem_a[bus_a.mem_adr[7:2]] <= bus_a.mem_wd;
      if (bus_b.mem_we === 1'b1) bmem_b[bus_b.mem_adr[7:2]] <= bus_b.mem_wd;
    end
    pipe_a    <= bus_a.mem_adr[7:2];
    pipe_b[0] <= bus_b.mem_adr[7:2];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign bus_a.mem_rd = bmem_a[pipe_a];
  assign bus_b.mem_rd = bmem_b[pipe_b[2]];

  // Scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input int k, input string name,
                       input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL dut%0d %s: got %h, expected %h (t=%0t)", k, name, act, exp, $time);
  endtask

  // Reference model: each accepted request becomes a scheduled transaction
  // with its IDLE sample cycle t0 and its response cycle.
  int unsigned  cyc = 0;
  bit           model_on = 1'b0;
  bit           done = 1'b0;
  bit           busy[2], own[2], mwe[2], last[2];
  int unsigned  t0[2], resp_c[2];
  logic [N-1:0] e_adr[2], e_wd[2], e_rd0[2], e_rd1[2], rdat[2];
  logic [N-1:0] mm[2][64];

  task automatic model_step(input int k);
    if (!reset) begin
      busy[k] = 1'b0;  last[k] = 1'b1;
      e_adr[k] = '0;   e_wd[k] = '0;
      e_rd0[k] = '0;   e_rd1[k] = '0;
      return;
    end
    if (busy[k]) begin
      if (cyc == resp_c[k] && !mwe[k]) begin
        if (own[k]) e_rd1[k] = rdat[k];
        else        e_rd0[k] = rdat[k];
      end
      if (cyc == resp_c[k] + 1) begin
        busy[k] = 1'b0;
        last[k] = own[k];
      end
    end else if (m0_req || m1_req) begin
      own[k]    = (m0_req && m1_req) ? !last[k] : m1_req;
      mwe[k]    = own[k] ? m1_we  : m0_we;
      e_adr[k]  = own[k] ? m1_adr : m0_adr;
      e_wd[k]   = own[k] ? m1_wd  : m0_wd;
      busy[k]   = 1'b1;
      t0[k]     = cyc - 1;
      resp_c[k] = mwe[k] ? t0[k] + 2 : t0[k] + lat_of(k) + 2;
      if (mwe[k]) mm[k][e_adr[k][7:2]] = e_wd[k];
      else        rdat[k] = mm[k][e_adr[k][7:2]];
    end
  endtask

  task automatic compare_outputs(input int k);
    logic [1:0] eg, es;
    logic       ew, er0, er1;
    eg = 2'b00; es = 2'd0; ew = 1'b0; er0 = 1'b0; er1 = 1'b0;
    if (busy[k]) begin
      eg  = own[k] ? 2'b10 : 2'b01;
      es  = (cyc == t0[k] + 1) ? 2'd1 : (cyc == resp_c[k]) ? 2'd3 : 2'd2;
      ew  = mwe[k] && (cyc == t0[k] + 1);
      er0 = (cyc == resp_c[k]) && !own[k];
      er1 = (cyc == resp_c[k]) &&  own[k];
    end
    check(k, "grant",    N'(o_grant[k]), N'(eg));
    check(k, "state",    N'(o_state[k]), N'(es));
    check(k, "mem_we",   N'(o_we[k]),    N'(ew));
    check(k, "m0_ready", N'(o_rdy0[k]),  N'(er0));
    check(k, "m1_ready", N'(o_rdy1[k]),  N'(er1));
    check(k, "mem_adr",  o_adr[k],       e_adr[k]);
    check(k, "mem_wd",   o_wd[k],        e_wd[k]);
    check(k, "m0_rd",    o_rd0[k],       e_rd0[k]);
    check(k, "m1_rd",    o_rd1[k],       e_rd1[k]);
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++) mm[k][i] = seed_word(i);
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) model_step(k);
      model_on = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_on && !done)
        for (int k = 0; k < 2; k++) compare_outputs(k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_seq[2][8];
  int         rr_n[2];
  logic [1:0] rr_prev[2];

  initial begin
    reset  = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h40; m0_wd = 32'hDEADBEEF;
    m1_req = 1'b0; m1_we = 1'b0; m1_adr = '0;     m1_wd = '0;

    // Reset held for two edges with m0 requesting, then a write to 0x40
    for (int i = 1; i <= 2; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        check(k, "rst_grant",  N'(o_grant[k]), N'(2'b00));
        check(k, "rst_mem_we", N'(o_we[k]),    N'(1'b0));
        check(k, "rst_ready",  N'(o_rdy0[k]),  N'(1'b0));
      end
    end
    reset = 1'b1;
    tick();
    m0_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check(k, "wr_grant",   N'(o_grant[k]), N'(2'b01));
      check(k, "wr_mem_we",  N'(o_we[k]),    N'(1'b1));
      check(k, "wr_mem_adr", o_adr[k],       32'h40);
      check(k, "wr_mem_wd",  o_wd[k],        32'hDEADBEEF);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      check(k, "wr_m0_ready", N'(o_rdy0[k]), N'(1'b1));
      check(k, "wr_m1_ready", N'(o_rdy1[k]), N'(1'b0));
      check(k, "wr_we_off",   N'(o_we[k]),   N'(1'b0));
    end
    tick();

    // m1 reads 0x40 back: ready at +3 (RD_LAT=1) and +5 (RD_LAT=3)
    m1_req = 1'b1; m1_we = 1'b0; m1_adr = 32'h40;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) m1_req = 1'b0;
      if (i == 3) begin
        check(0, "rd_m1_ready", N'(o_rdy1[0]), N'(1'b1));
        check(0, "rd_m1_rd",    o_rd1[0],      32'hDEADBEEF);
        check(0, "rd_m0_rd",    o_rd0[0],      32'h0);
      end
      if (i == 4) check(1, "rd_m1_early", N'(o_rdy1[1]), N'(1'b0));
      if (i == 5) begin
        check(1, "rd_m1_ready", N'(o_rdy1[1]), N'(1'b1));
        check(1, "rd_m1_rd",    o_rd1[1],      32'hDEADBEEF);
        check(1, "rd_m0_rd",    o_rd0[1],      32'h0);
      end
    end

    // m0 read with req dropped while waiting on memory
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h40;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) begin
        m0_req = 1'b0;
        check(0, "lat_m0_ready", N'(o_rdy0[0]), N'(1'b1));
      end
      if (i == 4) check(1, "lat_m0_early", N'(o_rdy0[1]), N'(1'b0));
      if (i == 5) begin
        check(1, "lat_m0_ready", N'(o_rdy0[1]), N'(1'b1));
        check(1, "lat_m0_rd",    o_rd0[1],      32'hDEADBEEF);
      end
      if (i == 6) check(1, "lat_m0_once", N'(o_rdy0[1]), N'(1'b0));
    end

    // Both ports request continuously: m0 went last, so m1, m0, m1, m0
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = 32'h100; m0_wd = 32'h0000AAAA;
    m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h104; m1_wd = 32'h0000BBBB;
    for (int k = 0; k < 2; k++) begin rr_n[k] = 0; rr_prev[k] = o_grant[k]; end
    for (int i = 1; i <= 12; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (o_grant[k] != 2'b00 && rr_prev[k] == 2'b00 && rr_n[k] < 8) begin
          rr_seq[k][rr_n[k]] = o_grant[k];
          rr_n[k]++;
        end
        rr_prev[k] = o_grant[k];
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check(k, "rr_count", N'(rr_n[k]), N'(4));
      for (int i = 0; i < 4 && i < rr_n[k]; i++)
        check(k, "rr_order", N'(rr_seq[k][i]), N'((i % 2 == 0) ? 2'b10 : 2'b01));
    end
    tick(); tick();

    // Reset during a read wait aborts it; a later m1 write is served normally
    m0_req = 1'b1; m0_we = 1'b0; m0_adr = 32'h40;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 1) m0_req = 1'b0;
      if (i == 2) reset = 1'b0;
      if (i == 3) begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) check(k, "abort_state", N'(o_state[k]), N'(2'd0));
      end
      if (i >= 3 && i <= 6)
        for (int k = 0; k < 2; k++) check(k, "abort_ready", N'(o_rdy0[k]), N'(1'b0));
      if (i == 6) begin
        m1_req = 1'b1; m1_we = 1'b1; m1_adr = 32'h44; m1_wd = 32'h12345678;
      end
      if (i == 7) begin
        m1_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
          check(k, "post_grant",   N'(o_grant[k]), N'(2'b10));
          check(k, "post_mem_we",  N'(o_we[k]),    N'(1'b1));
          check(k, "post_mem_adr", o_adr[k],       32'h44);
        end
      end
      if (i == 8)
        for (int k = 0; k < 2; k++) check(k, "post_m1_ready", N'(o_rdy1[k]), N'(1'b1));
    end

    // Random traffic, including occasional resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset  = ($urandom_range(0, 63) != 0);
      m0_req = 1'($urandom_range(0, 1));
      m1_req = 1'($urandom_range(0, 1));
      m0_we  = 1'($urandom_range(0, 1));
      m1_we  = 1'($urandom_range(0, 1));
      m0_adr = $urandom & 32'hF000_003C;
      m1_adr = $urandom & 32'hF000_003C;
      m0_wd  = $urandom;
      m1_wd  = $urandom;
    end
    tick();
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
